// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared constants, types and the feedback function for the 64-bit PRBS
// (x^64 + x^4 + x^3 + x + 1). The register shifts left and the new bit enters
// at bit 0. One 16-bit word on the link is the register's low 16 bits after
// each step.
// -----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_W  = 64;
  localparam int WORD_W  = 16;
  localparam logic [LFSR_W-1:0] TAP  = 64'h8000_0000_0000_000D; // bits 63,3,2,0
  localparam logic [LFSR_W-1:0] SEED = 64'h0000_0000_0000_0001;
  localparam int ACQ_LEN = 64;                        // consistent words needed to lock
  localparam int ACQ_W   = $clog2(ACQ_LEN + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // Feedback bit: XOR of the tapped register bits.
  function automatic logic lfsr64_fb(input logic [LFSR_W-1:0] state);
    return ^(state & TAP);
  endfunction

endpackage

// File: rtl/lfsr_popcount16.sv
// -----------------------------------------------------------------------------
// lfsr_popcount16
// Combinational population count of a 16-bit vector. The checker uses it to
// count the bit errors in a word. It is compiled only when
// LFSR_CHK_BITERR_EN is defined.
// Ports:
//   data   in  16  vector to count
//   count  out 5   number of ones in data (0..16)
// -----------------------------------------------------------------------------
`ifdef LFSR_CHK_BITERR_EN
module lfsr_popcount16 (
  input  logic [15:0] data,
  output logic [4:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(data[i]);
    end
  end

endmodule
`endif

// File: rtl/lfsr_64bit_checker.sv
// -----------------------------------------------------------------------------
// lfsr_64bit_checker
// Receive-side checker for the 64-bit PRBS generator. In HUNT the checker
// rebuilds the generator state from bit 0 of each incoming word. It also
// confirms the 15-bit overlap between consecutive words. After ACQ_LEN
// consistent words the checker locks. From then on a free-running reference
// predicts every word, and the checker counts the words that mismatch.
//
// Optional feature: define LFSR_CHK_BITERR_EN to add the bit_err_count output.
// That output accumulates the number of differing bits in each checked word.
//
// Ports:
//   clk            in   1      clock
//   rst_n          in   1      asynchronous active-low reset
//   in_valid       in   1      in_data carries one generator step this cycle
//   in_data        in   16     received word
//   clear          in   1      synchronous clear of the counters
//   locked         out  1      reference acquired, words being checked
//   err_pulse      out  1      one-cycle pulse, last checked word mismatched
//   lock_lost      out  1      one-cycle pulse, lock dropped
//   err_count      out  ERR_W  mismatching words since clear (saturating)
//   word_count     out  CNT_W  words checked since clear (saturating)
//   bit_err_count  out  ERR_W  bit errors since clear (LFSR_CHK_BITERR_EN only)
// -----------------------------------------------------------------------------
module lfsr_64bit_checker
  import lfsr_pkg::*;
#(
  parameter int ERR_W       = 16,
  parameter int CNT_W       = 32,
  parameter int LOSS_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic              lock_lost,
  output logic [ERR_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [ERR_W-1:0]  bit_err_count
`endif
);

  localparam int MISS_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  chk_state_t          state_q, state_d;
  // One register serves two roles. In HUNT it is the shift register fed with
  // received bits. In LOCKED it is the free-running reference. The acquired
  // state therefore becomes the reference without an extra copy.
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [WORD_W-1:0]   prev_q;
  logic [ACQ_W-1:0]    acq_q, acq_d, acq_inc;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic                err_pulse_d, lock_lost_d, check_word;

  logic [LFSR_W-1:0]   ref_next, hunt_next;
  logic [WORD_W-1:0]   exp_word;
  logic                consistent, mismatch;

  assign ref_next   = {lfsr_q[LFSR_W-2:0], lfsr64_fb(lfsr_q)};
  assign hunt_next  = {lfsr_q[LFSR_W-2:0], in_data[0]};
  assign exp_word   = ref_next[WORD_W-1:0];
  assign mismatch   = (in_data != exp_word);
  // acq_q == 0 marks the first word after reset or after re-entering HUNT.
  // That word has no predecessor, so it always starts a new run.
  assign consistent = (acq_q == '0) ||
                      (in_data[WORD_W-1:1] == prev_q[WORD_W-2:0]);
  assign acq_inc    = consistent ? acq_q + 1'b1 : ACQ_W'(1);
  assign miss_inc   = miss_q + 1'b1;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    acq_d       = acq_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    check_word  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          lfsr_d = hunt_next;
          acq_d  = acq_inc;
          if (acq_inc == ACQ_W'(ACQ_LEN)) begin
            if (hunt_next != '0) begin
              state_d = LOCKED;
              miss_d  = '0;
            end else begin
              // An all-zero state is the LFSR lock-up state and cannot seed.
              acq_d = ACQ_W'(1);
            end
          end
        end
        LOCKED: begin
          lfsr_d      = ref_next;
          check_word  = 1'b1;
          err_pulse_d = mismatch;
          if (mismatch) begin
            miss_d = miss_inc;
            if (miss_inc == MISS_W'(LOSS_THRESH)) begin
              state_d     = HUNT;
              lock_lost_d = 1'b1;
              acq_d       = '0;
              miss_d      = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments. All registers see
  // the same pre-edge values, so the order of the statements does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      lfsr_q    <= '0;
      prev_q    <= '0;
      acq_q     <= '0;
      miss_q    <= '0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      acq_q     <= acq_d;
      miss_q    <= miss_d;
      err_pulse <= err_pulse_d;
      lock_lost <= lock_lost_d;
      if (in_valid) prev_q <= in_data;
    end
  end

  assign locked = (state_q == LOCKED);

  // clear wins over a same-cycle increment. The pulses above do not depend
  // on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      word_count <= '0;
    end else if (clear) begin
      err_count  <= '0;
      word_count <= '0;
    end else begin
      if (err_pulse_d && (err_count != ERR_MAX)) err_count <= err_count + 1'b1;
      if (check_word && (word_count != '1))      word_count <= word_count + 1'b1;
    end
  end

`ifdef LFSR_CHK_BITERR_EN
  localparam int SUM_W = ERR_W + 5;
  logic [4:0]       bit_pop;
  logic [SUM_W-1:0] bit_sum;

  lfsr_popcount16 u_popcount (
    .data  (in_data ^ exp_word),
    .count (bit_pop)
  );

  assign bit_sum = SUM_W'(bit_err_count) + SUM_W'(bit_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_err_count <= '0;
    end else if (clear) begin
      bit_err_count <= '0;
    end else if (check_word) begin
      bit_err_count <= (bit_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : bit_sum[ERR_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_64bit_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_64bit_checker
// Bench for lfsr_64bit_checker. The stimulus is the PRBS stream with random
// in_valid gaps and random corruption. Each word also drives a behavioural
// model of the acquire, lock and check rules. The model keeps a run length
// and a queue of received bits, and tracks the checker outputs from them.
// A second instance with ERR_W=4 and LOSS_THRESH=255 is used for the
// saturation case.
// -----------------------------------------------------------------------------
module tb_lfsr_64bit_checker;
  import lfsr_pkg::*;

  localparam int ERR_W = 16;
  localparam int CNT_W = 32;
  localparam int LOSS  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, clear;
  logic [15:0] in_data;
  logic        locked, err_pulse, lock_lost;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] word_count;
  logic [ERR_W-1:0] bit_err_count;

  logic        s_valid, s_clear;
  logic [15:0] s_data;
  logic        s_locked, s_err_pulse, s_lock_lost;
  logic [3:0]  s_err_count;
  logic [CNT_W-1:0] s_word_count;
  logic [3:0]  s_bit_err_count;

  lfsr_64bit_checker #(.ERR_W(ERR_W), .CNT_W(CNT_W), .LOSS_THRESH(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
    .err_count(err_count), .word_count(word_count)
`ifdef LFSR_CHK_BITERR_EN
    , .bit_err_count(bit_err_count)
`endif
  );

  lfsr_64bit_checker #(.ERR_W(4), .CNT_W(CNT_W), .LOSS_THRESH(255)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_data(s_data), .clear(s_clear),
    .locked(s_locked), .err_pulse(s_err_pulse), .lock_lost(s_lock_lost),
    .err_count(s_err_count), .word_count(s_word_count)
`ifdef LFSR_CHK_BITERR_EN
    , .bit_err_count(s_bit_err_count)
`endif
  );

`ifndef LFSR_CHK_BITERR_EN
  assign bit_err_count   = '0;
  assign s_bit_err_count = '0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Generator and reference model state.
  logic [63:0] gen;
  bit          m_locked, m_ep, m_ll;
  int          m_run, m_miss, m_err, m_bits;
  longint      m_words;
  logic [15:0] m_last;
  logic [63:0] m_ref;
  bit          hist[$];

  function automatic logic [63:0] prbs_next(input logic [63:0] s);
    logic nb;
    nb = s[63] ^ s[3] ^ s[2] ^ s[0];
    return {s[62:0], nb};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_ep = 0; m_ll = 0;
    m_run = 0; m_miss = 0; m_err = 0; m_bits = 0; m_words = 0;
    m_last = '0; m_ref = '0;
    hist.delete();
  endtask

  task automatic model_word(input bit v, input logic [15:0] w, input bit c);
    logic [15:0] exp_w;
    logic [63:0] st;
    m_ep = 0; m_ll = 0;
    if (v) begin
      if (!m_locked) begin
        if (m_run == 0 || w[15:1] == m_last[14:0]) m_run++;
        else m_run = 1;
        m_last = w;
        hist.push_back(w[0]);
        if (hist.size() > 64) void'(hist.pop_front());
        if (m_run == ACQ_LEN) begin
          st = '0;
          foreach (hist[i]) st[63-i] = hist[i];
          if (st != '0) begin
            m_locked = 1; m_ref = st; m_miss = 0;
          end else begin
            m_run = 1;
          end
        end
      end else begin
        m_ref = prbs_next(m_ref);
        exp_w = m_ref[15:0];
        if (m_words < 64'hFFFF_FFFF) m_words++;
        if (w != exp_w) begin
          m_ep = 1;
          if (m_err < (1 << ERR_W) - 1) m_err++;
          m_bits = m_bits + $countones(w ^ exp_w);
          if (m_bits > (1 << ERR_W) - 1) m_bits = (1 << ERR_W) - 1;
          m_miss++;
          if (m_miss == LOSS) begin
            m_locked = 0; m_ll = 1; m_run = 0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) begin
      m_err = 0; m_words = 0; m_bits = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"},     64'(locked),     64'(m_locked));
    check({tag, ".err_pulse"},  64'(err_pulse),  64'(m_ep));
    check({tag, ".lock_lost"},  64'(lock_lost),  64'(m_ll));
    check({tag, ".err_count"},  64'(err_count),  64'(m_err));
    check({tag, ".word_count"}, 64'(word_count), 64'(m_words));
`ifdef LFSR_CHK_BITERR_EN
    check({tag, ".bit_err"},    64'(bit_err_count), 64'(m_bits));
`endif
  endtask

  // One clock with the given inputs; the model advances and outputs are
  // compared 1 time unit after the edge.
  task automatic step(input bit v, input logic [15:0] w, input bit c, input string tag);
    in_valid = v; in_data = w; clear = c;
    @(posedge clk);
    model_word(v, w, c);
    #1;
    check_all(tag);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  // Next generator word XOR mask, after 0..max_gap idle cycles with junk data.
  task automatic send(input logic [15:0] mask, input bit c, input int max_gap, input string tag);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) step(1'b0, 16'($urandom), 1'b0, {tag, ".gap"});
    step(1'b1, gen[15:0] ^ mask, c, tag);
    gen = prbs_next(gen);
  endtask

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    m = 16'($urandom);
    if (m == '0) m = 16'h0001;
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    s_valid = 1'b0; s_data = '0; s_clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Acquire from seed 1 with random gaps; lock appears one cycle after word 64.
    gen = SEED;
    for (int i = 0; i < ACQ_LEN - 1; i++) send(16'h0, 1'b0, 5, "acq_seed");
    check("acq_seed.not_yet", 64'(locked), 64'd0);
    send(16'h0, 1'b0, 5, "acq_seed.last");
    check("acq_seed.locked", 64'(locked), 64'd1);

    for (int i = 0; i < 20; i++) send(16'h0, 1'b0, 5, "clean");
    check("clean.err_count", 64'(err_count), 64'd0);
    check("clean.word_count", 64'(word_count), 64'd20);

    // Single bit flip, then an all-bits flip.
    send(16'h0020, 1'b0, 0, "bit5");
    check("bit5.err_pulse", 64'(err_pulse), 64'd1);
    check("bit5.err_count", 64'(err_count), 64'd1);
    send(16'h0, 1'b0, 0, "bit5.after");
    check("bit5.pulse_gone", 64'(err_pulse), 64'd0);
    send(16'hFFFF, 1'b0, 0, "all16");
`ifdef LFSR_CHK_BITERR_EN
    check("all16.bit_err", 64'(bit_err_count), 64'd17);
`endif

    // Sparse random corruption with random gaps.
    for (int i = 0; i < 48; i++)
      send(($urandom_range(5, 0) == 0) ? rand_mask() : 16'h0, 1'b0, 3, "sparse");

    // clear on the same cycle as an error.
    send(16'h0100, 1'b1, 0, "clr_err");
    check("clr_err.err_count", 64'(err_count), 64'd0);
    check("clr_err.err_pulse", 64'(err_pulse), 64'd1);
    step(1'b0, 16'h0, 1'b1, "clr_idle");

    // Eight consecutive bad words drop lock; clean stream relocks after 64.
    send(16'h0, 1'b0, 0, "pre_loss");
    for (int i = 0; i < LOSS - 1; i++) send(rand_mask(), 1'b0, 2, "loss");
    check("loss.still_locked", 64'(locked), 64'd1);
    send(rand_mask(), 1'b0, 0, "loss.last");
    check("loss.lock_lost", 64'(lock_lost), 64'd1);
    check("loss.locked", 64'(locked), 64'd0);
    for (int i = 0; i < ACQ_LEN - 1; i++) send(16'h0, 1'b0, 2, "relock");
    check("relock.not_yet", 64'(locked), 64'd0);
    send(16'h0, 1'b0, 0, "relock.last");
    check("relock.locked", 64'(locked), 64'd1);

    // Asynchronous reset while locked clears everything immediately.
    send(16'h0004, 1'b0, 0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Break the overlap at word 41; the run restarts there.
    for (int i = 0; i < 40; i++) send(16'h0, 1'b0, 1, "hunt");
    send(16'h8000, 1'b0, 0, "hunt.break");
    for (int i = 0; i < ACQ_LEN - 2; i++) send(16'h0, 1'b0, 1, "hunt.after");
    check("hunt.not_yet", 64'(locked), 64'd0);
    send(16'h0, 1'b0, 0, "hunt.last");
    check("hunt.locked", 64'(locked), 64'd1);

    // All-zero stream is consistent but must never lock.
    #2 rst_n = 1'b0;
    #1 model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < ACQ_LEN + 2; i++) step(1'b1, 16'h0, 1'b0, "zeros");
    check("zeros.locked", 64'(locked), 64'd0);

    // Saturation on the ERR_W=4 instance.
    gen = SEED;
    for (int i = 0; i < ACQ_LEN; i++) begin
      s_valid = 1'b1; s_data = gen[15:0]; gen = prbs_next(gen);
      @(posedge clk);
      #1;
    end
    check("sat.locked", 64'(s_locked), 64'd1);
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = gen[15:0] ^ 16'h0001; gen = prbs_next(gen);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("sat.err_count", 64'(s_err_count), 64'd15);
    check("sat.word_count", 64'(s_word_count), 64'd20);
    check("sat.still_locked", 64'(s_locked), 64'd1);
`ifdef LFSR_CHK_BITERR_EN
    check("sat.bit_err", 64'(s_bit_err_count), 64'd15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
